// File: rtl/ft600_tx_arbiter_if.sv
// Producer-side byte handshake, ring write port and pointer exchange for ft600_tx_arbiter.
// The arbiter uses the slave modport; producers and the ft600 core side use master.
interface ft600_tx_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               buf_we;
  logic [W-1:0]       buf_addr;
  logic [7:0]         buf_data;
  logic [W-1:0]       tx_buf_send;
  logic [W-1:0]       tx_buf_sent;
  logic               dbg_state;

  modport slave (
    input  req_valid, req_data, req_last, tx_buf_sent,
    output req_ready, grant, busy, buf_we, buf_addr, buf_data, tx_buf_send, dbg_state
  );

  modport master (
    output req_valid, req_data, req_last, tx_buf_sent,
    input  req_ready, grant, busy, buf_we, buf_addr, buf_data, tx_buf_send, dbg_state
  );
endinterface

// File: rtl/ft600_tx_arbiter.sv
// Round-robin arbiter sharing the FT600 TX ring between byte producers; writes accepted
// bytes into the ring and publishes the write pointer once the byte is stored.
module ft600_tx_arbiter #(
  parameter int N_REQ           = 2,
  parameter int TX_BUFFER       = 16,
  parameter int TX_BUFFER_WIDTH = $clog2(TX_BUFFER),
  parameter int MAX_BURST       = 8
) (
  input  logic              clk,
  input  logic              rst,
  ft600_tx_arbiter_if.slave bus
);
  localparam int W  = TX_BUFFER_WIDTH;
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [W-1:0] PTR_MASK = W'(TX_BUFFER - 1);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [W-1:0]     wr_ptr_q, send_q, buf_addr_q;
  logic [7:0]       buf_data_q;
  logic             buf_we_q;

  logic             full, xfer, stall, release_now, any_valid, found;
  logic             owner_valid, owner_last;
  logic [7:0]       owner_data;
  logic [OW-1:0]    sel, cand;

  // Handshake: a byte moves at a posedge where req_valid[i] & req_ready[i] are both 1.
  // req_ready depends only on registered state and tx_buf_sent, never on req_valid.
  assign full        = ((wr_ptr_q + W'(1)) & PTR_MASK) == bus.tx_buf_sent;
  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign owner_data  = bus.req_data[int'(owner_q)*8 +: 8];
  assign any_valid   = |bus.req_valid;
  assign xfer        = (state_q == S_GRANT) && owner_valid && !full;
  assign stall       = (state_q == S_GRANT) && !owner_valid && !full;
  assign release_now = stall || (xfer && (owner_last || burst_q == BW'(MAX_BURST - 1)));

  // Rotating priority: first valid requester after the previous owner.
  always_comb begin
    sel   = owner_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = OW'((int'(owner_q) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= OW'(N_REQ - 1);
      burst_q    <= '0;
      wr_ptr_q   <= '0;
      send_q     <= '0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      buf_we_q <= xfer;
      // Pointer publish lags the ring write by one cycle so the byte lands first.
      send_q   <= wr_ptr_q;
      if (xfer) begin
        buf_addr_q <= wr_ptr_q;
        buf_data_q <= owner_data;
        wr_ptr_q   <= (wr_ptr_q + W'(1)) & PTR_MASK;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d = S_GRANT;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          owner_d = sel;
          burst_d = '0;
        end
      end
      S_GRANT: begin
        if (xfer) burst_d = burst_q + BW'(1);
        if (release_now) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.req_ready   = (state_q == S_GRANT) ? (grant_q & {N_REQ{!full}}) : '0;
    bus.grant       = grant_q;
    bus.busy        = (state_q == S_GRANT);
    bus.dbg_state   = state_q;
    bus.buf_we      = buf_we_q;
    bus.buf_addr    = buf_addr_q;
    bus.buf_data    = buf_data_q;
    bus.tx_buf_send = send_q;
  end
endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// Directed bench for ft600_tx_arbiter: producer queues drive bytes, a monitor checks ring
// writes and grant order against hand-computed expectations.
module tb_ft600_tx_arbiter;
  logic clk;
  logic rst;
  bit   drain;
  int   errors;
  int   checks;

  logic [11:0] exp_q[$];    // {addr, data} of each expected ring write
  logic [5:0]  exp_g_q[$];  // {idle gap (0 = any), one-hot grant}
  logic [8:0]  pq0[$];      // {last, data} pending at producer 0
  logic [8:0]  pq1[$];

  ft600_tx_arbiter_if #(.N_REQ(2), .W(4)) bus ();

  ft600_tx_arbiter #(.N_REQ(2), .TX_BUFFER(16), .MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // producer driver
  initial begin
    logic [1:0] acc;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      if (acc[0] && pq0.size() > 0) void'(pq0.pop_front());
      if (acc[1] && pq1.size() > 0) void'(pq1.pop_front());
      bus.req_valid[0] = (pq0.size() > 0);
      bus.req_data[7:0] = (pq0.size() > 0) ? pq0[0][7:0] : 8'h00;
      bus.req_last[0]  = (pq0.size() > 0) ? pq0[0][8] : 1'b0;
      bus.req_valid[1] = (pq1.size() > 0);
      bus.req_data[15:8] = (pq1.size() > 0) ? pq1[0][7:0] : 8'h00;
      bus.req_last[1]  = (pq1.size() > 0) ? pq1[0][8] : 1'b0;
    end
  end

  // ft600 core stand-in: consumes everything published when drain is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drain) bus.tx_buf_sent = bus.tx_buf_send;
    end
  end

  // scoreboard monitor
  initial begin
    logic [1:0]  prev_grant;
    logic [11:0] e;
    logic [5:0]  g;
    int          idle_run;
    prev_grant = '0;
    idle_run   = 0;
    forever begin
      @(negedge clk);
      if (bus.buf_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL buf_write: got addr=%0d data=%02h, expected no write", bus.buf_addr, bus.buf_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.buf_addr, bus.buf_data} !== e) begin
            errors++;
            $display("FAIL buf_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                     bus.buf_addr, bus.buf_data, e[11:8], e[7:0]);
          end
        end
      end
      if (bus.grant != 2'b00) begin
        if (prev_grant == 2'b00) begin
          checks++;
          if (exp_g_q.size() == 0) begin
            errors++;
            $display("FAIL grant_order: got grant=%b, expected no new grant", bus.grant);
          end else begin
            g = exp_g_q.pop_front();
            if (bus.grant !== g[1:0] || (g[5:2] != 0 && idle_run != int'(g[5:2]))) begin
              errors++;
              $display("FAIL grant_order: got grant=%b gap=%0d, expected grant=%b gap=%0d",
                       bus.grant, idle_run, g[1:0], g[5:2]);
            end
          end
        end
        idle_run = 0;
      end else if (idle_run < 15) begin
        idle_run++;
      end
      prev_grant = bus.grant;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int req, input logic [7:0] d, input logic last,
                           input logic [3:0] addr);
    if (req == 0) pq0.push_back({last, d});
    else          pq1.push_back({last, d});
    exp_q.push_back({addr, d});
  endtask

  task automatic wait_drained(input int max_cyc, input string name);
    int n;
    n = 0;
    checks++;
    while (!(pq0.size() == 0 && pq1.size() == 0 && bus.grant == 2'b00 && !bus.buf_we)
           && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, expected drained", name, max_cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"},    32'(bus.grant), 0);
    chk({tag, "_busy"},     32'(bus.busy), 0);
    chk({tag, "_ready"},    32'(bus.req_ready), 0);
    chk({tag, "_buf_we"},   32'(bus.buf_we), 0);
    chk({tag, "_buf_addr"}, 32'(bus.buf_addr), 0);
    chk({tag, "_buf_data"}, 32'(bus.buf_data), 0);
    chk({tag, "_tx_send"},  32'(bus.tx_buf_send), 0);
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    drain  = 1'b0;
    bus.tx_buf_sent = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // single packet from req0
    exp_g_q.push_back({4'd0, 2'b01});
    push_byte(0, 8'h10, 1'b0, 4'd0);
    push_byte(0, 8'h11, 1'b0, 4'd1);
    push_byte(0, 8'h12, 1'b1, 4'd2);
    wait_drained(50, "single_pkt");
    chk("single_tx_send", 32'(bus.tx_buf_send), 3);
    chk("single_grant",   32'(bus.grant), 0);

    // both streaming without last: 8 bytes per grant, alternating
    drain = 1'b1;
    @(negedge clk);
    exp_g_q.push_back({4'd0, 2'b01});
    exp_g_q.push_back({4'd1, 2'b10});
    exp_g_q.push_back({4'd1, 2'b01});
    for (int i = 0; i < 8; i++) push_byte(0, 8'h20 + 8'(i), 1'b0, 4'(3 + i));
    for (int i = 0; i < 8; i++) exp_q.push_back({4'(11 + i), 8'h30 + 8'(i)});
    for (int i = 8; i < 16; i++) push_byte(0, 8'h20 + 8'(i), 1'b0, 4'(3 + i - 8));
    @(negedge clk);
    for (int i = 0; i < 8; i++) pq1.push_back({1'b0, 8'h30 + 8'(i)});
    wait_drained(200, "burst_rr");
    chk("burst_tx_send", 32'(bus.tx_buf_send), 11);

    // fill: consumer stuck at 0
    drain = 1'b0;
    rst   = 1'b0;
    bus.tx_buf_sent = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_g_q.push_back({4'd0, 2'b01});
    exp_g_q.push_back({4'd1, 2'b01});
    for (int i = 0; i < 16; i++) push_byte(0, 8'h40 + 8'(i), (i == 15), 4'(i));
    n = 0;
    checks++;
    while (pq0.size() != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL fill_wait: %0d bytes pending, expected 1", pq0.size());
    end
    repeat (3) @(negedge clk);
    chk("fill_grant_held", 32'(bus.grant), 32'h1);
    chk("fill_ready_low",  32'(bus.req_ready), 0);
    chk("fill_busy",       32'(bus.busy), 1);
    chk("fill_tx_send",    32'(bus.tx_buf_send), 15);
    @(posedge clk);
    #2;
    bus.tx_buf_sent = 4'd1;
    wait_drained(50, "fill_release");
    chk("fill_tx_send_wrap", 32'(bus.tx_buf_send), 0);
    chk("fill_grant_idle",   32'(bus.grant), 0);

    // move pointers to 14, then a wrapping packet from req1
    drain = 1'b1;
    @(negedge clk);
    exp_g_q.push_back({4'd0, 2'b01});
    exp_g_q.push_back({4'd1, 2'b01});
    for (int i = 0; i < 14; i++) push_byte(0, 8'h50 + 8'(i), (i == 13), 4'(i));
    wait_drained(100, "pre_wrap");
    chk("pre_wrap_tx_send", 32'(bus.tx_buf_send), 14);
    exp_g_q.push_back({4'd0, 2'b10});
    push_byte(1, 8'h60, 1'b0, 4'd14);
    push_byte(1, 8'h61, 1'b0, 4'd15);
    push_byte(1, 8'h62, 1'b0, 4'd0);
    push_byte(1, 8'h63, 1'b1, 4'd1);
    wait_drained(50, "wrap");
    chk("wrap_tx_send", 32'(bus.tx_buf_send), 2);

    // req1 stalls after 2 bytes; waiting req0 goes next, then req1 again
    exp_g_q.push_back({4'd0, 2'b10});
    exp_g_q.push_back({4'd1, 2'b01});
    exp_g_q.push_back({4'd0, 2'b10});
    pq1.push_back({1'b0, 8'h70});
    pq1.push_back({1'b0, 8'h71});
    exp_q.push_back({4'd2, 8'h70});
    exp_q.push_back({4'd3, 8'h71});
    @(negedge clk);
    push_byte(0, 8'h80, 1'b0, 4'd4);
    push_byte(0, 8'h81, 1'b0, 4'd5);
    push_byte(0, 8'h82, 1'b1, 4'd6);
    exp_q.push_back({4'd7, 8'h72});
    n = 0;
    checks++;
    while (pq1.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL stall_wait: %0d bytes pending at req1, expected 0", pq1.size());
    end
    repeat (3) @(negedge clk);
    pq1.push_back({1'b1, 8'h72});
    wait_drained(50, "stall");
    chk("stall_tx_send", 32'(bus.tx_buf_send), 8);

    // reset in the middle of a req1 burst
    exp_g_q.push_back({4'd0, 2'b10});
    for (int i = 0; i < 6; i++) pq1.push_back({1'b0, 8'h90 + 8'(i)});
    exp_q.push_back({4'd8, 8'h90});
    exp_q.push_back({4'd9, 8'h91});
    n = 0;
    checks++;
    while (bus.grant != 2'b10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL midrst_wait: grant=%b, expected 10", bus.grant);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    drain = 1'b0;
    bus.tx_buf_sent = '0;
    @(negedge clk);
    pq0.delete();
    pq1.delete();
    exp_g_q.push_back({4'd0, 2'b01});
    exp_g_q.push_back({4'd1, 2'b10});
    push_byte(0, 8'hB0, 1'b0, 4'd0);
    push_byte(0, 8'hB1, 1'b1, 4'd1);
    push_byte(1, 8'hA0, 1'b0, 4'd2);
    push_byte(1, 8'hA1, 1'b1, 4'd3);
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    drain = 1'b1;
    wait_drained(50, "post_rst");
    chk("post_rst_tx_send", 32'(bus.tx_buf_send), 4);

    chk("writes_left", 32'(exp_q.size()), 0);
    chk("grants_left", 32'(exp_g_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
